pgr_fft_in: RTL and testbench

Input stage of the burst FFT/IFFT core; the write-side counterpart of the core's output streamer. It accepts one frame of complex samples on an AXI-stream slave and packs each even/odd sample pair into one write of the dual-bank (A/B) working RAM. It repairs frames with a wrong TLAST by zero-padding or truncating, then pulses `fft_start` and holds off new input until the core reports `fft_cdone`.

---
 rtl/pgr_fft_pkg.sv | 32 +++
 rtl/pgr_fft_in.sv | 179 +++++++++++++++++
 tb/tb_pgr_fft_in.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pgr_fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pgr_fft_pkg
// Brief    : Shared FSM encoding and parameter checks for the FFT in/out streamers
// Revision : 1.0 - initial release
// ============================================================================
package pgr_fft_pkg;

    localparam int          c_state_w  = 3;
    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_fill  = 3'd1;
    localparam logic [2:0]  c_st_pad   = 3'd2;
    localparam logic [2:0]  c_st_drain = 3'd3;
    localparam logic [2:0]  c_st_start = 3'd4;
    localparam logic [2:0]  c_st_wait  = 3'd5;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE  = c_st_idle,
        ST_FILL  = c_st_fill,
        ST_PAD   = c_st_pad,
        ST_DRAIN = c_st_drain,
        ST_START = c_st_start,
        ST_WAIT  = c_st_wait
    } fft_state_t;

    // dft_length must be wide enough to express N-1 for the largest bank.
    function automatic bit widths_consistent(input int len_w, input int addr_w);
        return len_w >= addr_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pgr_fft_in.sv
`default_nettype none
// ============================================================================
// Module   : pgr_fft_in
// Brief    : AXI-stream frame input stage; packs sample pairs into A/B banks
// Revision : 1.0 - initial release
// ============================================================================
module pgr_fft_in #(
    parameter int LEN_WIDTH  = 10,
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_WIDTH-1:0]  dft_length,
    input  logic [DATA_WIDTH-1:0] s_axi_data,
    input  logic                  s_axi_valid,
    input  logic                  s_axi_last,
    output logic                  s_axi_ready,
    output logic                  o_wr_enable,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] oa_wr_data,
    output logic [DATA_WIDTH-1:0] ob_wr_data,
    output logic                  fft_start,
    input  logic                  fft_cdone,
    output logic                  tlast_err
);
    import pgr_fft_pkg::*;

    if (!widths_consistent(LEN_WIDTH, ADDR_WIDTH)) begin : g_param_check
        $error("pgr_fft_in: LEN_WIDTH must be at least ADDR_WIDTH+1");
    end

    if (LEN_WIDTH > ADDR_WIDTH + 1) begin : g_len_upper
        logic w_unused_len_upper;
        assign w_unused_len_upper = ^dft_length[LEN_WIDTH-1:ADDR_WIDTH+1];
    end

    fft_state_t            r_state,     w_state_next;
    logic [ADDR_WIDTH:0]   r_cnt,       w_cnt_next;
    logic [ADDR_WIDTH:0]   r_len,       w_len_next;
    logic [ADDR_WIDTH-1:0] r_pad_addr,  w_pad_addr_next;
    logic [DATA_WIDTH-1:0] r_even,      w_even_next;
    logic                  r_ready,     w_ready_next;
    logic                  r_wr_enable, w_wr_enable_next;
    logic [ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr_next;
    logic [DATA_WIDTH-1:0] r_wr_a,      w_wr_a_next;
    logic [DATA_WIDTH-1:0] r_wr_b,      w_wr_b_next;
    logic                  r_tlast_err, w_tlast_err_next;
    logic                  w_hs;

    assign w_hs = s_axi_valid & r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_pad_addr  <= '0;
            r_even      <= '0;
            r_ready     <= 1'b0;
            r_wr_enable <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_a      <= '0;
            r_wr_b      <= '0;
            r_tlast_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_len       <= w_len_next;
            r_pad_addr  <= w_pad_addr_next;
            r_even      <= w_even_next;
            r_ready     <= w_ready_next;
            r_wr_enable <= w_wr_enable_next;
            r_wr_addr   <= w_wr_addr_next;
            r_wr_a      <= w_wr_a_next;
            r_wr_b      <= w_wr_b_next;
            r_tlast_err <= w_tlast_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_len_next       = r_len;
        w_pad_addr_next  = r_pad_addr;
        w_even_next      = r_even;
        w_wr_enable_next = 1'b0;
        w_wr_addr_next   = r_wr_addr;
        w_wr_a_next      = r_wr_a;
        w_wr_b_next      = r_wr_b;
        w_tlast_err_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_len_next   = dft_length[ADDR_WIDTH:0];
                w_cnt_next   = '0;
                w_state_next = ST_FILL;
            end
            ST_FILL: begin
                if (w_hs) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (!r_cnt[0]) begin
                        w_even_next = s_axi_data;
                    end else begin
                        w_wr_enable_next = 1'b1;
                        w_wr_addr_next   = r_cnt[ADDR_WIDTH:1];
                        w_wr_a_next      = r_even;
                        w_wr_b_next      = s_axi_data;
                    end
                    if (r_cnt == r_len) begin
                        if (s_axi_last) begin
                            w_state_next = ST_START;
                        end else begin
                            w_tlast_err_next = 1'b1;
                            w_state_next     = ST_DRAIN;
                        end
                    end else if (s_axi_last) begin
                        // Early end: close the current pair, then zero-fill the rest.
                        w_tlast_err_next = 1'b1;
                        if (!r_cnt[0]) begin
                            w_wr_enable_next = 1'b1;
                            w_wr_addr_next   = r_cnt[ADDR_WIDTH:1];
                            w_wr_a_next      = s_axi_data;
                            w_wr_b_next      = '0;
                        end
                        w_pad_addr_next = r_cnt[ADDR_WIDTH:1] + 1'b1;
                        if (r_cnt[ADDR_WIDTH:1] == r_len[ADDR_WIDTH:1]) begin
                            w_state_next = ST_START;
                        end else begin
                            w_state_next = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                w_wr_enable_next = 1'b1;
                w_wr_addr_next   = r_pad_addr;
                w_wr_a_next      = '0;
                w_wr_b_next      = '0;
                if (r_pad_addr == r_len[ADDR_WIDTH:1]) begin
                    w_state_next = ST_START;
                end else begin
                    w_pad_addr_next = r_pad_addr + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_hs && s_axi_last) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                // Hold until the final write has left the output register.
                if (!r_wr_enable) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fft_cdone) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_ready_next = (w_state_next == ST_FILL) || (w_state_next == ST_DRAIN);
    end

    assign s_axi_ready = r_ready;
    assign o_wr_enable = r_wr_enable;
    assign o_wr_addr   = r_wr_addr;
    assign oa_wr_data  = r_wr_a;
    assign ob_wr_data  = r_wr_b;
    assign tlast_err   = r_tlast_err;
    assign fft_start   = (r_state == ST_START) && !r_wr_enable;

endmodule
`default_nettype wire

// File: tb/tb_pgr_fft_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_pgr_fft_in
// Brief    : Randomized self-checking bench for pgr_fft_in against a frame model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pgr_fft_in;
    localparam int LW = 10;
    localparam int DW = 36;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] dft_length;
    logic [DW-1:0] s_axi_data;
    logic          s_axi_valid;
    logic          s_axi_last;
    logic          s_axi_ready;
    logic          o_wr_enable;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] oa_wr_data;
    logic [DW-1:0] ob_wr_data;
    logic          fft_start;
    logic          fft_cdone;
    logic          tlast_err;

    pgr_fft_in #(.LEN_WIDTH(LW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .dft_length(dft_length),
        .s_axi_data(s_axi_data), .s_axi_valid(s_axi_valid), .s_axi_last(s_axi_last),
        .s_axi_ready(s_axi_ready), .o_wr_enable(o_wr_enable), .o_wr_addr(o_wr_addr),
        .oa_wr_data(oa_wr_data), .ob_wr_data(ob_wr_data), .fft_start(fft_start),
        .fft_cdone(fft_cdone), .tlast_err(tlast_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            addr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            c;
    } wr_t;

    wr_t obs_q[$];
    int  terr_n = 0, terr_c = 0, start_n = 0, start_c = 0;

    always @(negedge clk) begin
        if (o_wr_enable) obs_q.push_back('{int'(o_wr_addr), oa_wr_data, ob_wr_data, cyc});
        if (tlast_err) begin terr_n++; terr_c = cyc; end
        if (fft_start) begin start_n++; start_c = cyc; end
    end

    int n_chk = 0, n_pass = 0;
    int cd_edge = 0;
    logic [DW-1:0] beat_d [0:2047];
    int            hs_edge[0:2047];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic drive_frame(input int nbeats, input int lastpos, input int gap, input bit seq);
        int  i = 0;
        int  t = 0;
        bit  acc = 1'b0;
        logic [63:0] r;
        for (int k = 0; k < nbeats; k++) begin
            r = {$urandom, $urandom};
            beat_d[k] = seq ? DW'(k + 1) : r[DW-1:0];
        end
        while (i < nbeats && t < 20000) begin
            @(negedge clk);
            t++;
            if (acc) begin s_axi_valid = 1'b0; s_axi_last = 1'b0; acc = 1'b0; end
            if (!s_axi_valid && i < nbeats && (i == 0 || $urandom_range(99) >= gap)) begin
                s_axi_valid = 1'b1;
                s_axi_data  = beat_d[i];
                s_axi_last  = (i == lastpos);
            end
            if (s_axi_valid && s_axi_ready) begin
                hs_edge[i] = cyc + 1;
                i++;
                acc = 1'b1;
            end
        end
        check("drive_beats_accepted", i, nbeats);
        @(negedge clk);
        s_axi_valid = 1'b0;
        s_axi_last  = 1'b0;
    endtask

    task automatic pulse_cdone();
        @(negedge clk);
        s_axi_valid = 1'b0;
        fft_cdone   = 1'b1;
        cd_edge     = cyc + 1;
        @(negedge clk);
        fft_cdone   = 1'b0;
    endtask

    task automatic run_frame(input int n, input int nbeats, input int lastpos,
                             input int gap, input bit seq, input bit chk_b2b);
        int t0, s0, w, ntake, eidx, npad, exp_start, acc;
        logic [DW-1:0] ea, eb;
        int ec;
        obs_q.delete();
        t0 = terr_n;
        s0 = start_n;
        drive_frame(nbeats, lastpos, gap, seq);
        w = 0;
        while (start_n == s0 && w < 3000) begin
            @(negedge clk); #1; w++;
        end
        check("fft_start_count", start_n - s0, 1);
        if (chk_b2b) check("b2b_first_accept", hs_edge[0] - cd_edge, 2);

        // Reference: frame = beats up to the first TLAST (or N beats), zero-padded to N.
        ntake = imin(lastpos + 1, n);
        eidx  = imin(lastpos, n - 1);
        if (lastpos == n - 1) begin
            check("tlast_err_count", terr_n - t0, 0);
            exp_start = hs_edge[n - 1] + 1;
        end else begin
            check("tlast_err_count", terr_n - t0, 1);
            check("tlast_err_cycle", terr_c, hs_edge[eidx]);
            if (lastpos > n - 1) begin
                exp_start = hs_edge[lastpos];
            end else begin
                npad = n / 2 - 1 - lastpos / 2;
                exp_start = hs_edge[lastpos] + npad + 1;
            end
        end
        check("fft_start_cycle", start_c, exp_start);

        for (int k = 0; k < n / 2 && k < obs_q.size(); k++) begin
            ea = (2 * k < ntake)     ? beat_d[2 * k]     : '0;
            eb = (2 * k + 1 < ntake) ? beat_d[2 * k + 1] : '0;
            if (2 * k + 1 < ntake)  ec = hs_edge[2 * k + 1];
            else if (2 * k < ntake) ec = hs_edge[2 * k];
            else                    ec = hs_edge[lastpos] + (k - lastpos / 2);
            check("wr_addr", obs_q[k].addr, k);
            check("wr_a",    obs_q[k].a,    ea);
            check("wr_b",    obs_q[k].b,    eb);
            check("wr_cycle", obs_q[k].c,   ec);
        end

        s_axi_valid = 1'b1;
        s_axi_data  = DW'(36'h0DEAD);
        s_axi_last  = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (s_axi_ready) acc++;
        end
        s_axi_valid = 1'b0;
        check("ready_low_in_wait", acc, 0);
        check("wr_count", obs_q.size(), n / 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, typ, lp, nb, s0;
        rst_n       = 1'b0;
        dft_length  = LW'(7);
        s_axi_data  = '0;
        s_axi_valid = 1'b0;
        s_axi_last  = 1'b0;
        fft_cdone   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready",   s_axi_ready, 0);
        check("rst_wr_en",   o_wr_enable, 0);
        check("rst_wr_addr", o_wr_addr,   0);
        check("rst_a",       oa_wr_data,  0);
        check("rst_b",       ob_wr_data,  0);
        check("rst_start",   fft_start,   0);
        check("rst_terr",    tlast_err,   0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(8, 8, 7, 0, 1'b1, 1'b0);
        dft_length = LW'(7);   pulse_cdone(); run_frame(8, 8, 7, 40, 1'b0, 1'b1);
        dft_length = LW'(7);   pulse_cdone(); run_frame(8, 5, 4, 0, 1'b1, 1'b1);
        dft_length = LW'(7);   pulse_cdone(); run_frame(8, 11, 10, 0, 1'b1, 1'b1);
        dft_length = LW'(1);   pulse_cdone(); run_frame(2, 2, 1, 30, 1'b0, 1'b1);
        dft_length = LW'(1023); pulse_cdone(); run_frame(1024, 1024, 1023, 20, 1'b0, 1'b1);

        for (int f = 0; f < 8; f++) begin
            n   = 2 << $urandom_range(5);
            typ = $urandom_range(2);
            if (typ == 0) begin
                lp = n - 1; nb = n;
            end else if (typ == 1) begin
                lp = $urandom_range(n - 2); nb = lp + 1;
            end else begin
                nb = n + 1 + $urandom_range(3); lp = nb - 1;
            end
            dft_length = LW'(n - 1);
            pulse_cdone();
            run_frame(n, nb, lp, 35, 1'b0, 1'b1);
        end

        // Reset in the middle of a frame.
        dft_length = LW'(15);
        pulse_cdone();
        drive_frame(6, -1, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready",   s_axi_ready, 0);
        check("midrst_wr_en",   o_wr_enable, 0);
        check("midrst_wr_addr", o_wr_addr,   0);
        check("midrst_a",       oa_wr_data,  0);
        check("midrst_b",       ob_wr_data,  0);
        check("midrst_start",   fft_start,   0);
        check("midrst_terr",    tlast_err,   0);
        obs_q.delete();
        s0 = start_n;
        dft_length = LW'(7);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("midrst_no_start", start_n - s0, 0);
        check("midrst_no_write", obs_q.size(), 0);
        run_frame(8, 8, 7, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
